riscv_control_fsm: RTL

//  Multicycle control unit driving the shared-bus RISC-V datapath: sequences fetch, decode, execute, memory and PC-update
//  by asserting the datapath's load/enable/select strobes each cycle. Consumes datapath IR contents, ALU zero and memory busy.

---
 rtl/riscv_ctrl_pkg.sv | 53 +++++
 rtl/alu_decoder.sv | 32 +++
 rtl/riscv_control_fsm.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the multicycle RISC-V control unit: state encoding,
// opcode constants, ALU operation codes and datapath select codes.
package riscv_ctrl_pkg;

  localparam int STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH0  = 4'd0,
    S_FETCH1  = 4'd1,
    S_DECODE  = 4'd2,
    S_RS2     = 4'd3,
    S_IMM     = 4'd4,
    S_EXEC    = 4'd5,
    S_MEMRD   = 4'd6,
    S_MEMWR   = 4'd7,
    S_PCNEXT0 = 4'd8,
    S_PCNEXT1 = 4'd9,
    S_PCNEXT2 = 4'd10,
    S_TRAP    = 4'd11
  } state_t;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [1:0] EXT_I    = 2'd0;
  localparam logic [1:0] EXT_S    = 2'd1;
  localparam logic [1:0] EXT_B    = 2'd2;
  localparam logic [1:0] EXT_FOUR = 2'd3;

  localparam logic [1:0] SEL_RS1 = 2'd0;
  localparam logic [1:0] SEL_RS2 = 2'd1;
  localparam logic [1:0] SEL_RD  = 2'd2;
  localparam logic [1:0] SEL_PC  = 2'd3;

  // Second operand comes from the register file (rs2) rather than the immediate.
  function automatic logic uses_rs2(input logic [6:0] op);
    return (op == OP_R) || (op == OP_BEQ);
  endfunction

  function automatic logic uses_imm(input logic [6:0] op);
    return (op == OP_I) || (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU operation decode from opcode/funct3/funct7[5], with a flag
// for encodings the datapath cannot execute.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7_b5,
  output logic [3:0] o_alu_control,
  output logic       o_unsupported
);

  always_comb begin
    o_alu_control = ALU_ADD;
    o_unsupported = 1'b0;
    case (i_opcode)
      OP_R, OP_I: begin
        case (i_funct3)
          3'b000:  o_alu_control = (i_opcode == OP_R && i_funct7_b5) ? ALU_SUB : ALU_ADD;
          3'b111:  o_alu_control = ALU_AND;
          3'b110:  o_alu_control = ALU_OR;
          3'b010:  o_alu_control = ALU_SLT;
          default: o_unsupported = 1'b1;
        endcase
      end
      OP_LW, OP_SW: o_alu_control = ALU_ADD;
      OP_BEQ:       o_alu_control = ALU_SUB;
      default:      o_unsupported = 1'b1;
    endcase
  end

endmodule

// File: rtl/riscv_control_fsm.sv
// Multicycle control unit for the shared-bus RISC-V datapath. Outputs are a
// Moore decode of state, refined by ir/taken/mem_busy in a few states.
//
// state   | meaning
// FETCH0  | PC onto bus, load MA
// FETCH1  | memory read into IR, waits out mem_busy
// DECODE  | rs1 into A, pick operand-B source by opcode
// RS2     | rs2 into B
// IMM     | sign-extended immediate into B
// EXEC    | ALU result to rd, or address into MA, or BEQ compare
// MEMRD   | memory data written to rd
// MEMWR   | rs2 drives bus, memory write
// PCNEXT0 | PC into A
// PCNEXT1 | +4 or branch offset into B
// PCNEXT2 | PC <= A + B, instruction complete
// TRAP    | illegal instruction, parked until reset
module riscv_control_fsm
  import riscv_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ir,
  input  logic        zero,
  input  logic        mem_busy,
  output logic [3:0]  ALUControl,
  output logic        lda,
  output logic        ldb,
  output logic        ldma,
  output logic        ldiR,
  output logic [1:0]  reg_sel,
  output logic        reg_en,
  output logic        reg_we,
  output logic        mem_en,
  output logic        mem_we,
  output logic        alu_en,
  output logic        IMM_en,
  output logic [1:0]  ExtendSign_sel,
  output logic        instr_done,
  output logic        illegal
);

  state_t     r_state;
  logic       r_taken;
  logic [6:0] w_opcode;
  logic [3:0] w_alu_ctrl;
  logic       w_unsupported;
  logic       w_ir_unused;

  assign w_opcode    = ir[6:0];
  assign w_ir_unused = ^{ir[31], ir[29:15], ir[11:7]};

  alu_decoder u_alu_decoder (
    .i_opcode      (w_opcode),
    .i_funct3      (ir[14:12]),
    .i_funct7_b5   (ir[30]),
    .o_alu_control (w_alu_ctrl),
    .o_unsupported (w_unsupported)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_FETCH0;
      r_taken <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH0: r_state <= S_FETCH1;
        S_FETCH1: if (!mem_busy) r_state <= S_DECODE;
        S_DECODE: begin
          if (uses_rs2(w_opcode))      r_state <= S_RS2;
          else if (uses_imm(w_opcode)) r_state <= S_IMM;
          else                         r_state <= S_TRAP;
        end
        S_RS2:    r_state <= S_EXEC;
        S_IMM:    r_state <= S_EXEC;
        S_EXEC: begin
          if (w_unsupported) begin
            r_state <= S_TRAP;
          end else begin
            case (w_opcode)
              OP_LW:   r_state <= S_MEMRD;
              OP_SW:   r_state <= S_MEMWR;
              OP_BEQ: begin
                r_taken <= zero;
                r_state <= S_PCNEXT0;
              end
              default: r_state <= S_PCNEXT0;
            endcase
          end
        end
        S_MEMRD:   if (!mem_busy) r_state <= S_PCNEXT0;
        S_MEMWR:   if (!mem_busy) r_state <= S_PCNEXT0;
        S_PCNEXT0: r_state <= S_PCNEXT1;
        S_PCNEXT1: r_state <= S_PCNEXT2;
        S_PCNEXT2: begin
          r_taken <= 1'b0;
          r_state <= S_FETCH0;
        end
        S_TRAP:    r_state <= S_TRAP;
        default:   r_state <= S_TRAP;
      endcase
    end
  end

  // Only one bus driver per cycle: register reads are suppressed whenever
  // memory or the ALU owns the bus, including while memory is stalled.
  always_comb begin
    ALUControl     = ALU_AND;
    lda            = 1'b0;
    ldb            = 1'b0;
    ldma           = 1'b0;
    ldiR           = 1'b0;
    reg_sel        = SEL_RS1;
    reg_en         = 1'b0;
    reg_we         = 1'b0;
    mem_en         = 1'b0;
    mem_we         = 1'b0;
    alu_en         = 1'b0;
    IMM_en         = 1'b0;
    ExtendSign_sel = EXT_I;
    instr_done     = 1'b0;
    illegal        = 1'b0;
    if (rst) begin
      case (r_state)
        S_FETCH0: begin
          reg_sel = SEL_PC;
          reg_en  = 1'b1;
          ldma    = 1'b1;
        end
        S_FETCH1: begin
          mem_en = 1'b1;
          ldiR   = !mem_busy;
        end
        S_DECODE: begin
          reg_sel = SEL_RS1;
          reg_en  = 1'b1;
          lda     = 1'b1;
        end
        S_RS2: begin
          reg_sel = SEL_RS2;
          reg_en  = 1'b1;
          ldb     = 1'b1;
        end
        S_IMM: begin
          IMM_en         = 1'b1;
          ldb            = 1'b1;
          ExtendSign_sel = (w_opcode == OP_SW) ? EXT_S : EXT_I;
        end
        S_EXEC: begin
          if (!w_unsupported) begin
            alu_en     = 1'b1;
            ALUControl = w_alu_ctrl;
            case (w_opcode)
              OP_LW, OP_SW: ldma = 1'b1;
              OP_BEQ: ;
              default: begin
                reg_sel = SEL_RD;
                reg_en  = 1'b1;
                reg_we  = 1'b1;
              end
            endcase
          end
        end
        S_MEMRD: begin
          mem_en  = 1'b1;
          reg_sel = SEL_RD;
          reg_en  = !mem_busy;
          reg_we  = !mem_busy;
        end
        S_MEMWR: begin
          reg_sel = SEL_RS2;
          reg_en  = !mem_busy;
          mem_en  = !mem_busy;
          mem_we  = !mem_busy;
        end
        S_PCNEXT0: begin
          reg_sel = SEL_PC;
          reg_en  = 1'b1;
          lda     = 1'b1;
        end
        S_PCNEXT1: begin
          IMM_en         = 1'b1;
          ldb            = 1'b1;
          ExtendSign_sel = r_taken ? EXT_B : EXT_FOUR;
        end
        S_PCNEXT2: begin
          alu_en     = 1'b1;
          ALUControl = ALU_ADD;
          reg_sel    = SEL_PC;
          reg_en     = 1'b1;
          reg_we     = 1'b1;
          instr_done = 1'b1;
        end
        S_TRAP:  illegal = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
